uart_tx_rr_sched: RTL and testbench



---
 rtl/uart_tx_rr_sched_if.sv | 27 ++
 rtl/uart_tx_rr_sched.sv | 130 +++++++++++++
 tb/tb_uart_tx_rr_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_rr_sched_if.sv
// Bundle between the byte producers, the round-robin scheduler and the uart_tx serializer.
// The scheduler takes the master modport. The producers and serializer side take the slave modport.
interface uart_tx_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_id;
    logic                 err_timeout;
    logic [15:0]          frames_sent;

    modport master (
        input  req, req_data, tx_busy,
        output ack, tx_start, tx_data, grant_valid, grant_id, err_timeout, frames_sent
    );

    modport slave (
        output req, req_data, tx_busy,
        input  ack, tx_start, tx_data, grant_valid, grant_id, err_timeout, frames_sent
    );
endinterface

// File: rtl/uart_tx_rr_sched.sv
// Round-robin share of one uart_tx between NUM_REQ producers; one frame in flight at a time.
// req->tx_start/ack: 1 cycle. New grants are held off while tx_busy is high or a frame is outstanding.
// Flags a serializer that never goes busy (sticky err_timeout) and counts completed frames.
module uart_tx_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int BUSY_TO = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_rr_sched_if.master  bus
);
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic               err_timeout_q, err_timeout_d;
    logic [15:0]        frames_sent_q, frames_sent_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    int                 idx;

    // First set request at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        err_timeout_d = err_timeout_q;
        frames_sent_d = frames_sent_q;
        case (state_q)
            ARB: begin
                if (!bus.tx_busy && found) begin
                    tx_data_d     = bus.req_data[int'(win)*8 +: 8];
                    grant_id_d    = win;
                    ptr_d         = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    tx_start_d    = 1'b1;
                    ack_d         = NUM_REQ'(1) << win;
                    grant_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == CNT_W'(BUSY_TO)) begin
                        err_timeout_d = 1'b1;
                        grant_valid_d = 1'b0;
                        state_d       = ARB;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    frames_sent_d = frames_sent_q + 16'd1;
                    grant_valid_d = 1'b0;
                    state_d       = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB;
            ptr_q         <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            err_timeout_q <= 1'b0;
            frames_sent_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            err_timeout_q <= err_timeout_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.frames_sent = frames_sent_q;
endmodule

// File: tb/tb_uart_tx_rr_sched.sv
// Directed bench for uart_tx_rr_sched with a small uart_tx model (16 clocks per bit).
module tb_uart_tx_rr_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_rr_sched_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

    uart_tx_rr_sched #(.NUM_REQ(4), .IDX_W(2), .BUSY_TO(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // uart_tx model: busy from the edge after tx_start for 10 bit times.
    logic       model_en = 1'b1;
    logic       busy_m   = 1'b0;
    logic [9:0] shreg    = 10'h3FF;
    int         tick     = 0;
    int         bitn     = 0;
    logic       line;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m <= 1'b0;
            shreg  <= 10'h3FF;
            tick   <= 0;
            bitn   <= 0;
        end else if (!busy_m) begin
            if (model_en && bus.tx_start) begin
                busy_m <= 1'b1;
                shreg  <= {1'b1, bus.tx_data, 1'b0};
                tick   <= 0;
                bitn   <= 0;
            end
        end else if (tick == 15) begin
            tick  <= 0;
            shreg <= {1'b1, shreg[9:1]};
            if (bitn == 9) busy_m <= 1'b0;
            else           bitn   <= bitn + 1;
        end else begin
            tick <= tick + 1;
        end
    end
    assign bus.tx_busy = busy_m;
    assign line        = busy_m ? shreg[0] : 1'b1;

    // Line sampler: mid-bit samples of start, 8 data bits and stop.
    logic [9:0] cap = '0;
    initial begin
        forever begin
            @(negedge line);
            repeat (8) @(posedge clk);
            for (int b = 0; b < 10; b++) begin
                cap[b] = line;
                if (b < 9) repeat (16) @(posedge clk);
            end
        end
    end

    // Protocol monitor.
    int cyc = 0, fall_cyc = -1, last_gap = -1;
    int viol = 0, starts = 0, acks = 0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        busy_prev <= bus.tx_busy;
        if (busy_prev && !bus.tx_busy) fall_cyc <= cyc;
        if (!rst) begin
            if (bus.tx_start && bus.tx_busy) viol <= viol + 1;
            if (bus.tx_start) starts <= starts + 1;
            if (bus.ack != 4'b0) acks <= acks + 1;
            if (bus.tx_start && fall_cyc >= 0) begin
                last_gap <= cyc - fall_cyc;
                fall_cyc <= -1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int maxc, output int lat);
        lat = 0;
        while (lat < maxc) begin
            @(negedge clk);
            lat++;
            if (bus.tx_start) break;
        end
        check({tag, "_start"}, 32'(bus.tx_start), 32'd1);
    endtask

    task automatic wait_frames(input string tag, input logic [15:0] exp, input int maxc);
        int n = 0;
        while (bus.frames_sent !== exp && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.frames_sent), 32'(exp));
    endtask

    int lat;

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",   32'(bus.ack), 32'd0);
        check("rst_start", 32'(bus.tx_start), 32'd0);
        check("rst_data",  32'(bus.tx_data), 32'd0);
        check("rst_gv",    32'(bus.grant_valid), 32'd0);
        check("rst_gid",   32'(bus.grant_id), 32'd0);
        check("rst_err",   32'(bus.err_timeout), 32'd0);
        check("rst_frm",   32'(bus.frames_sent), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request with serialized line check.
        bus.req_data[7:0] = 8'hA5;
        bus.req = 4'b0001;
        wait_start("t1", 10, lat);
        check("t1_lat",  32'(lat), 32'd1);
        check("t1_ack",  32'(bus.ack), 32'h1);
        check("t1_data", 32'(bus.tx_data), 32'hA5);
        check("t1_gv",   32'(bus.grant_valid), 32'd1);
        bus.req = 4'b0000;
        wait_frames("t1_frm", 16'd1, 400);
        check("t1_start_bit", 32'(cap[0]), 32'd0);
        check("t1_byte",      32'(cap[8:1]), 32'hA5);
        check("t1_stop_bit",  32'(cap[9]), 32'd1);

        // All four requesting continuously.
        do_reset();
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_start("t2", 400, lat);
            check("t2_gid",  32'(bus.grant_id), 32'(k % 4));
            check("t2_data", 32'(bus.tx_data), 32'h10 + 32'(k % 4));
            check("t2_ack",  32'(bus.ack), 32'(1 << (k % 4)));
            if (k == 7) bus.req = 4'b0000;
        end
        wait_frames("t2_frm", 16'd8, 400);
        check("t2_no_start_busy", 32'(viol), 32'd0);
        check("t2_gap", 32'(last_gap), 32'd2);
        check("t2_ack_eq_start", 32'(acks), 32'(starts));

        // Fairness: 2 continuous, 0 arrives mid-frame.
        do_reset();
        bus.req_data = {8'h23, 8'h22, 8'h21, 8'h20};
        bus.req = 4'b0100;
        wait_start("t3a", 20, lat);
        check("t3_g0", 32'(bus.grant_id), 32'd2);
        repeat (20) @(negedge clk);
        bus.req[0] = 1'b1;
        wait_start("t3b", 400, lat);
        check("t3_g1", 32'(bus.grant_id), 32'd0);
        check("t3_d1", 32'(bus.tx_data), 32'h20);
        bus.req[0] = 1'b0;
        wait_start("t3c", 400, lat);
        check("t3_g2", 32'(bus.grant_id), 32'd2);
        bus.req = 4'b0000;
        wait_frames("t3_frm", 16'd3, 400);

        // Busy timeout: serializer never goes busy.
        model_en = 1'b0;
        do_reset();
        bus.req = 4'b0010;
        wait_start("t4", 20, lat);
        check("t4_gid", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) check("t4_err_early", 32'(bus.err_timeout), 32'd0);
            if (k == 5) begin
                check("t4_err",   32'(bus.err_timeout), 32'd1);
                check("t4_gv",    32'(bus.grant_valid), 32'd0);
                check("t4_frm",   32'(bus.frames_sent), 32'd0);
            end
        end
        bus.req = 4'b0010;
        wait_start("t4r", 10, lat);
        check("t4_rearb_gid", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0000;
        repeat (10) @(negedge clk);
        check("t4_err_sticky", 32'(bus.err_timeout), 32'd1);
        check("t4_frm_after",  32'(bus.frames_sent), 32'd0);

        // Reset mid-frame.
        model_en = 1'b1;
        do_reset();
        bus.req_data[15:8] = 8'h55;
        bus.req = 4'b0010;
        wait_start("t5", 20, lat);
        bus.req = 4'b0000;
        repeat (20) @(negedge clk);
        check("t5_gv_mid", 32'(bus.grant_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_gv",   32'(bus.grant_valid), 32'd0);
        check("t5_data", 32'(bus.tx_data), 32'd0);
        check("t5_gid",  32'(bus.grant_id), 32'd0);
        check("t5_err",  32'(bus.err_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1010;
        wait_start("t5r", 20, lat);
        check("t5_first_gid", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0000;
        wait_frames("t5_frm", 16'd1, 400);

        // Frame counter wrap.
        @(negedge clk);
        force dut.frames_sent_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frames_sent_q;
        check("t6_forced", 32'(bus.frames_sent), 32'hFFFF);
        bus.req = 4'b0001;
        wait_start("t6", 20, lat);
        bus.req = 4'b0000;
        wait_frames("t6_wrap", 16'h0000, 400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
